// File: rtl/shuffle_ctrl.sv
// shuffle_ctrl
//
// Sequencing controller for the 3-parallel data shuffler that sits between
// radix-3 FFT stages. It tracks the commutation phase, steers the three
// output-lane muxes, enables the delay buffers and regenerates the valid and
// start-of-frame markers at the shuffler output. All controller state moves
// on the rising edge of clk. The lane buffers capture on the falling edge, so
// the selects are already stable half a cycle before they are used.
//
// Parameters
//   D       delay depth per lane in groups (commutation period P = 3*D), D >= 1
//   CNT_W   phase counter width
//   FILL_W  fill / start-of-frame counter width
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a 3-sample group is on the shuffler inputs
//   in_sof     in   that group starts a frame (only meaningful with in_valid)
//   buf_en     out  buffer enable, combinationally equal to in_valid
//   sel0..2    out  source-lane select for output lanes 0..2 (registered)
//   out_valid  out  shuffler output group valid (registered)
//   out_sof    out  shuffler output group starts a frame (registered)
//   err_sync   out  one-cycle pulse on a frame sync violation (registered)

module shuffle_ctrl #(
    parameter int D      = 4,
    parameter int CNT_W  = $clog2(3*D),
    parameter int FILL_W = $clog2(2*D+1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       buf_en,
    output logic [1:0] sel0,
    output logic [1:0] sel1,
    output logic [1:0] sel2,
    output logic       out_valid,
    output logic       out_sof,
    output logic       err_sync
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(3*D - 1);
    localparam logic [CNT_W-1:0]  PH1_START = CNT_W'(D);
    localparam logic [CNT_W-1:0]  PH2_START = CNT_W'(2*D);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(2*D);
    localparam logic [FILL_W-1:0] SOF_LAST  = FILL_W'(1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FILL_W-1:0] fcnt_q, fcnt_d;
    logic [FILL_W-1:0] sofcnt_q, sofcnt_d;
    logic [1:0]        sel0_q, sel0_d;
    logic [1:0]        sel1_q, sel1_d;
    logic [1:0]        sel2_q, sel2_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              err_sync_q, err_sync_d;

    logic [CNT_W-1:0]  ce;
    logic [1:0]        ph;

    // A start-of-frame forces the group onto phase position 0, whatever the
    // running counter says.
    always_comb begin
        ce = in_sof ? '0 : cnt_q;
        if (ce < PH1_START) begin
            ph = 2'd0;
        end else if (ce < PH2_START) begin
            ph = 2'd1;
        end else begin
            ph = 2'd2;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        fcnt_d      = fcnt_q;
        sofcnt_d    = sofcnt_q;
        sel0_d      = sel0_q;
        sel1_d      = sel1_q;
        sel2_d      = sel2_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        err_sync_d  = 1'b0;

        if (in_valid) begin
            cnt_d = (ce == CNT_LAST) ? '0 : ce + CNT_W'(1);

            if (fcnt_q != FILL_FULL) begin
                fcnt_d = fcnt_q + FILL_W'(1);
            end

            // A new sof always restarts the frame countdown; any out_sof still
            // pending from the previous frame is abandoned.
            if (in_sof) begin
                sofcnt_d = FILL_FULL;
            end else if (sofcnt_q != '0) begin
                sofcnt_d = sofcnt_q - FILL_W'(1);
            end

            // Output lane k takes input lane (k + ph) mod 3.
            case (ph)
                2'd0: begin
                    sel0_d = 2'd0;
                    sel1_d = 2'd1;
                    sel2_d = 2'd2;
                end
                2'd1: begin
                    sel0_d = 2'd1;
                    sel1_d = 2'd2;
                    sel2_d = 2'd0;
                end
                default: begin
                    sel0_d = 2'd2;
                    sel1_d = 2'd0;
                    sel2_d = 2'd1;
                end
            endcase

            out_valid_d = (fcnt_q == FILL_FULL);
            out_sof_d   = ~in_sof & (sofcnt_q == SOF_LAST);
            // Misalignment and frame overlap share one pulse.
            err_sync_d  = in_sof & ((cnt_q != '0) | (sofcnt_q != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            fcnt_q      <= '0;
            sofcnt_q    <= '0;
            sel0_q      <= 2'd0;
            sel1_q      <= 2'd1;
            sel2_q      <= 2'd2;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            err_sync_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            sofcnt_q    <= sofcnt_d;
            sel0_q      <= sel0_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            err_sync_q  <= err_sync_d;
        end
    end

    assign buf_en    = in_valid;
    assign sel0      = sel0_q;
    assign sel1      = sel1_q;
    assign sel2      = sel2_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign err_sync  = err_sync_q;

endmodule

// File: tb/tb_shuffle_ctrl.sv
// Testbench for shuffle_ctrl with D = 4 (P = 12).
// Directed table of a fresh continuous stream, the same table with bubbles,
// hand sequences for the sync corner cases and asynchronous reset, then a
// randomized run against a group-counting reference model.

module tb_shuffle_ctrl;

    localparam int D = 4;
    localparam int P = 3 * D;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic       buf_en;
    logic [1:0] sel0, sel1, sel2;
    logic       out_valid, out_sof, err_sync;

    shuffle_ctrl #(.D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .buf_en    (buf_en),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .err_sync  (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts groups rather than mirroring counters.
    //   m_acc   groups accepted since reset
    //   m_pos   groups since the last sof (or reset), modulo P
    //   m_since 0 = no frame pending; k = k-th group counted from the sof group
    int m_acc, m_pos, m_since;
    int e_sel0, e_sel1, e_sel2, e_ov, e_osof, e_err;

    typedef struct {
        logic v;
        logic s;
        int   s0, s1, s2;
        int   ov, osof, err;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_pos   = 0;
        m_since = 0;
        e_sel0  = 0;
        e_sel1  = 1;
        e_sel2  = 2;
        e_ov    = 0;
        e_osof  = 0;
        e_err   = 0;
    endtask

    task automatic model_step(input logic v, input logic s);
        int idx, ph;
        if (!v) begin
            e_ov   = 0;
            e_osof = 0;
            e_err  = 0;
        end else begin
            idx    = s ? 0 : m_pos;
            ph     = idx / D;
            e_sel0 = ph % 3;
            e_sel1 = (1 + ph) % 3;
            e_sel2 = (2 + ph) % 3;
            e_ov   = (m_acc >= 2 * D) ? 1 : 0;
            e_osof = (!s && m_since == 2 * D) ? 1 : 0;
            e_err  = (s && (m_pos != 0 || (m_since != 0 && m_since <= 2 * D))) ? 1 : 0;
            if (m_acc < 1000) m_acc++;
            if (s) begin
                m_pos   = 1 % P;
                m_since = 1;
            end else begin
                m_pos = (m_pos + 1) % P;
                if (m_since != 0 && m_since <= 2 * D) m_since++;
            end
        end
    endtask

    // Drive one cycle from just after a rising edge; compare everything
    // against the model just after the next rising edge.
    task automatic grp(input logic v, input logic s);
        in_valid = v;
        in_sof   = s;
        #1;
        chk("buf_en", int'(buf_en), int'(v));
        @(posedge clk);
        #1;
        model_step(v, s);
        chk("sel0", int'(sel0), e_sel0);
        chk("sel1", int'(sel1), e_sel1);
        chk("sel2", int'(sel2), e_sel2);
        chk("out_valid", int'(out_valid), e_ov);
        chk("out_sof", int'(out_sof), e_osof);
        chk("err_sync", int'(err_sync), e_err);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        #1;
        chk("rst_buf_en", int'(buf_en), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_sel0", int'(sel0), 0);
        chk("rst_sel1", int'(sel1), 1);
        chk("rst_sel2", int'(sel2), 2);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_err_sync", int'(err_sync), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic run_table(input bit bubbles);
        string tag;
        tag = bubbles ? "bub" : "cont";
        do_reset();
        for (int g = 0; g < 25; g++) begin
            if (bubbles && g > 0) begin
                grp(1'b0, 1'b0);
                chk({tag, "_hold_sel0"}, int'(sel0), tbl[g-1].s0);
                chk({tag, "_hold_sel1"}, int'(sel1), tbl[g-1].s1);
                chk({tag, "_hold_sel2"}, int'(sel2), tbl[g-1].s2);
                chk({tag, "_idle_ov"}, int'(out_valid), 0);
            end
            grp(tbl[g].v, tbl[g].s);
            chk({tag, "_sel0"}, int'(sel0), tbl[g].s0);
            chk({tag, "_sel1"}, int'(sel1), tbl[g].s1);
            chk({tag, "_sel2"}, int'(sel2), tbl[g].s2);
            chk({tag, "_ov"}, int'(out_valid), tbl[g].ov);
            chk({tag, "_osof"}, int'(out_sof), tbl[g].osof);
            chk({tag, "_err"}, int'(err_sync), tbl[g].err);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        model_reset();

        // Continuous-stream expectations straight from the phase schedule.
        for (int g = 0; g < 25; g++) begin
            int ph;
            ph          = (g % P) / D;
            tbl[g].v    = 1'b1;
            tbl[g].s    = (g == 0);
            tbl[g].s0   = ph;
            tbl[g].s1   = (1 + ph) % 3;
            tbl[g].s2   = (2 + ph) % 3;
            tbl[g].ov   = (g >= 8) ? 1 : 0;
            tbl[g].osof = (g == 8) ? 1 : 0;
            tbl[g].err  = 0;
        end

        run_table(1'b0);
        run_table(1'b1);

        // Misaligned sof at cnt = 5 after the fill has completed.
        do_reset();
        grp(1'b1, 1'b1);
        for (int g = 1; g < 17; g++) grp(1'b1, 1'b0);
        grp(1'b1, 1'b1);
        chk("mis_err", int'(err_sync), 1);
        chk("mis_sel0", int'(sel0), 0);
        chk("mis_sel1", int'(sel1), 1);
        chk("mis_sel2", int'(sel2), 2);
        for (int j = 1; j <= 8; j++) begin
            grp(1'b1, 1'b0);
            chk("mis_err_after", int'(err_sync), 0);
            chk("mis_osof", int'(out_sof), (j == 8) ? 1 : 0);
        end

        // Overlapping sof, aligned to P: two frames, no error.
        do_reset();
        for (int g = 0; g < 25; g++) begin
            grp(1'b1, (g == 0 || g == 12));
            chk("ovl_err", int'(err_sync), 0);
            chk("ovl_osof", int'(out_sof), (g == 8 || g == 20) ? 1 : 0);
        end

        // Overlapping sof at group 4: error, first frame's marker dropped.
        do_reset();
        for (int g = 0; g < 25; g++) begin
            grp(1'b1, (g == 0 || g == 4));
            chk("ovl4_err", int'(err_sync), (g == 4) ? 1 : 0);
            chk("ovl4_osof", int'(out_sof), (g == 12) ? 1 : 0);
        end

        // Reset mid-frame, asserted between clock edges.
        do_reset();
        for (int g = 0; g < 10; g++) grp(1'b1, (g == 0));
        chk("mid_ov_before", int'(out_valid), 1);
        chk("mid_sel0_before", int'(sel0), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_async_sel0", int'(sel0), 0);
        chk("mid_async_sel1", int'(sel1), 1);
        chk("mid_async_sel2", int'(sel2), 2);
        chk("mid_async_ov", int'(out_valid), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int g = 0; g < 12; g++) begin
            grp(1'b1, 1'b0);
            chk("mid_refill_ov", int'(out_valid), (g >= 8) ? 1 : 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic v, s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 15) == 0) || (m_pos == 0 && $urandom_range(0, 2) == 0);
            grp(v, s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
